// File: rtl/button_cmd_scheduler_if.sv
// rtl/button_cmd_scheduler_if.sv - button input and command/mode output bundle for button_cmd_scheduler
interface button_cmd_scheduler_if;
  logic [3:0] btn_pulse;
  logic [3:0] btn_level;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [2:0] mode;
  logic       set_active;
  logic       overrun;

  modport master (
    input  btn_pulse, btn_level, cmd_ready,
    output cmd_valid, cmd_code, mode, set_active, overrun
  );

  modport slave (
    output btn_pulse, btn_level, cmd_ready,
    input  cmd_valid, cmd_code, mode, set_active, overrun
  );
endinterface

// File: rtl/button_cmd_scheduler.sv
// rtl/button_cmd_scheduler.sv - queues button pulses into one command stream, auto-repeat and mode FSM
module button_cmd_scheduler #(
  parameter int unsigned HOLD_CYC    = 50000000,
  parameter int unsigned REP_CYC     = 10000000,
  parameter int unsigned TIMEOUT_CYC = 1000000000,
  parameter int unsigned CW          = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  button_cmd_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    M_TIME      = 3'd0,
    M_SET_HR    = 3'd1,
    M_SET_MIN   = 3'd2,
    M_ALM_HR    = 3'd3,
    M_ALM_MIN   = 3'd4,
    M_STOPWATCH = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_HOLD = 2'd1,
    R_RPT  = 2'd2
  } rpt_e;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic [3:0]    pending_q, pending_d;
  logic [1:0]    rpt_pending_q, rpt_pending_d;
  logic          valid_q, valid_d;
  logic [2:0]    code_q, code_d;
  mode_e         mode_q, mode_d;
  logic          overrun_q, overrun_d;
  logic [CW-1:0] idle_q, idle_d;
  rpt_e          rpt_state_q, rpt_state_d;
  logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_sel_q, rpt_sel_d;

  logic [5:0] req;
  logic [5:0] grant;
  logic [2:0] grant_code;
  logic       free;
  logic       set_act;
  logic       timeout;
  logic       mode_chg;
  logic       abort;
  logic [1:0] fire;
  mode_e      base_mode;

  always_comb begin
    pending_d     = pending_q;
    rpt_pending_d = rpt_pending_q;
    valid_d       = valid_q;
    code_d        = code_q;
    mode_d        = mode_q;
    overrun_d     = overrun_q;
    idle_d        = idle_q;
    rpt_state_d   = rpt_state_q;
    rpt_cnt_d     = rpt_cnt_q;
    rpt_sel_d     = rpt_sel_q;
    grant         = '0;
    grant_code    = '0;
    fire          = '0;
    abort         = 1'b0;
    base_mode     = mode_q;

    // Bit order doubles as priority: MODE, SEL, UP, DOWN, UP_RPT, DOWN_RPT.
    req  = {rpt_pending_q, pending_q};
    free = !valid_q || bus.cmd_ready;
    if (free) begin
      for (int i = 5; i >= 0; i--) begin
        if (req[i]) begin
          grant      = '0;
          grant[i]   = 1'b1;
          grant_code = 3'(i + 1);
        end
      end
      valid_d = |req;
      if (|req) code_d = grant_code;
    end

    pending_d = (pending_q & ~grant[3:0]) | bus.btn_pulse;
    overrun_d = overrun_q | (|(bus.btn_pulse & pending_q & ~grant[3:0]));

    set_act = (mode_q == M_SET_HR) || (mode_q == M_SET_MIN) ||
              (mode_q == M_ALM_HR) || (mode_q == M_ALM_MIN);
    timeout = set_act && (idle_q == TO_LAST);

    // A command granted on the timeout edge sees TIME as its starting mode.
    base_mode = timeout ? M_TIME : mode_q;
    mode_d    = base_mode;
    if (grant[0]) begin
      case (base_mode)
        M_TIME:      mode_d = M_STOPWATCH;
        M_STOPWATCH: mode_d = M_ALM_HR;
        default:     mode_d = M_TIME;
      endcase
    end else if (grant[1]) begin
      case (base_mode)
        M_TIME:    mode_d = M_SET_HR;
        M_SET_HR:  mode_d = M_SET_MIN;
        M_SET_MIN: mode_d = M_TIME;
        M_ALM_HR:  mode_d = M_ALM_MIN;
        M_ALM_MIN: mode_d = M_TIME;
        default:   mode_d = base_mode;
      endcase
    end
    mode_chg = (mode_d != mode_q);

    idle_d = ((|grant) || mode_chg || !set_act) ? '0 : sat_inc(idle_q);

    abort = (rpt_sel_q ? !bus.btn_level[3] : !bus.btn_level[2]) ||
            (bus.btn_level[2] && bus.btn_level[3]);
    case (rpt_state_q)
      R_IDLE: begin
        if (bus.btn_level[2] ^ bus.btn_level[3]) begin
          rpt_state_d = R_HOLD;
          rpt_sel_d   = bus.btn_level[3];
          rpt_cnt_d   = '0;
        end
      end
      R_HOLD: begin
        if (abort) begin
          rpt_state_d = R_IDLE;
          rpt_cnt_d   = '0;
        end else if (rpt_cnt_q == HOLD_LAST) begin
          fire[rpt_sel_q] = 1'b1;
          rpt_cnt_d       = '0;
          rpt_state_d     = R_RPT;
        end else begin
          rpt_cnt_d = sat_inc(rpt_cnt_q);
        end
      end
      R_RPT: begin
        if (abort) begin
          rpt_state_d = R_IDLE;
          rpt_cnt_d   = '0;
        end else if (rpt_cnt_q == REP_LAST) begin
          fire[rpt_sel_q] = 1'b1;
          rpt_cnt_d       = '0;
        end else begin
          rpt_cnt_d = sat_inc(rpt_cnt_q);
        end
      end
      default: begin
        rpt_state_d = R_IDLE;
        rpt_cnt_d   = '0;
      end
    endcase
    if (!set_act || mode_chg) begin
      rpt_state_d = R_IDLE;
      rpt_cnt_d   = '0;
      fire        = '0;
    end

    rpt_pending_d = mode_chg ? 2'b00 : ((rpt_pending_q & ~grant[5:4]) | fire);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q     <= '0;
      rpt_pending_q <= '0;
      valid_q       <= 1'b0;
      code_q        <= '0;
      mode_q        <= M_TIME;
      overrun_q     <= 1'b0;
      idle_q        <= '0;
      rpt_state_q   <= R_IDLE;
      rpt_cnt_q     <= '0;
      rpt_sel_q     <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      rpt_pending_q <= rpt_pending_d;
      valid_q       <= valid_d;
      code_q        <= code_d;
      mode_q        <= mode_d;
      overrun_q     <= overrun_d;
      idle_q        <= idle_d;
      rpt_state_q   <= rpt_state_d;
      rpt_cnt_q     <= rpt_cnt_d;
      rpt_sel_q     <= rpt_sel_d;
    end
  end

  assign bus.cmd_valid  = valid_q;
  assign bus.cmd_code   = code_q;
  assign bus.mode       = mode_q;
  assign bus.set_active = set_act;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// tb/tb_button_cmd_scheduler.sv - directed self-checking bench for button_cmd_scheduler
module tb_button_cmd_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   n_del;

  always #5 clk = ~clk;

  button_cmd_scheduler_if bus_if ();

  button_cmd_scheduler #(
    .HOLD_CYC   (8),
    .REP_CYC    (4),
    .TIMEOUT_CYC(64),
    .CW         (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus_if.btn_pulse = 4'b0000;
    bus_if.btn_level = 4'b0000;
    bus_if.cmd_ready = 1'b1;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    logic [2:0] exp_code [7];

    // Test 1: reset state, single UP pulse at cycle 10
    bus_if.btn_pulse = 4'b0000;
    bus_if.btn_level = 4'b0000;
    bus_if.cmd_ready = 1'b1;
    reset = 1'b0;
    step();
    chk("rst_valid", bus_if.cmd_valid, 0);
    chk("rst_code", bus_if.cmd_code, 0);
    chk("rst_mode", bus_if.mode, 0);
    chk("rst_overrun", bus_if.overrun, 0);
    chk("rst_set_active", bus_if.set_active, 0);
    step();
    reset = 1'b1;
    for (int c = 0; c < 15; c++) begin
      bus_if.btn_pulse = (c == 10) ? 4'b0100 : 4'b0000;
      chk("t1_valid", bus_if.cmd_valid, (c == 12));
      if (c == 12) chk("t1_code", bus_if.cmd_code, 3);
      step();
    end
    chk("t1_mode", bus_if.mode, 0);
    chk("t1_overrun", bus_if.overrun, 0);

    // Test 2: MODE, UP, DOWN in the same cycle
    do_reset();
    exp_code = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd4, 3'd0, 3'd0};
    for (int c = 0; c < 7; c++) begin
      bus_if.btn_pulse = (c == 0) ? 4'b1101 : 4'b0000;
      chk("t2_valid", bus_if.cmd_valid, (exp_code[c] != 3'd0));
      if (exp_code[c] != 3'd0) chk("t2_code", bus_if.cmd_code, exp_code[c]);
      chk("t2_mode", bus_if.mode, (c >= 2) ? 5 : 0);
      step();
    end
    chk("t2_overrun", bus_if.overrun, 0);

    // Test 3: stalled SEL, overrun on the third pulse, two deliveries
    do_reset();
    bus_if.cmd_ready = 1'b0;
    bus_if.btn_pulse = 4'b0010;
    step();
    bus_if.btn_pulse = 4'b0000;
    step();
    chk("t3_valid_c2", bus_if.cmd_valid, 1);
    chk("t3_code_c2", bus_if.cmd_code, 2);
    chk("t3_mode_c2", bus_if.mode, 1);
    step();
    bus_if.btn_pulse = 4'b0010;
    step();
    bus_if.btn_pulse = 4'b0000;
    chk("t3_valid_c4", bus_if.cmd_valid, 1);
    chk("t3_code_c4", bus_if.cmd_code, 2);
    chk("t3_overrun_c4", bus_if.overrun, 0);
    step();
    bus_if.btn_pulse = 4'b0010;
    step();
    bus_if.btn_pulse = 4'b0000;
    chk("t3_overrun_c6", bus_if.overrun, 1);
    chk("t3_code_c6", bus_if.cmd_code, 2);
    chk("t3_mode_c6", bus_if.mode, 1);
    bus_if.cmd_ready = 1'b1;
    n_del = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus_if.cmd_valid === 1'b1) begin
        chk("t3_del_code", bus_if.cmd_code, 2);
        n_del++;
      end
      step();
    end
    chk("t3_deliveries", n_del, 2);
    chk("t3_mode_end", bus_if.mode, 2);

    // Test 4: UP held in SET_HR produces repeats, both levels stop them
    do_reset();
    bus_if.btn_pulse = 4'b0010;
    step();
    bus_if.btn_pulse = 4'b0000;
    step();
    chk("t4_mode_sethr", bus_if.mode, 1);
    chk("t4_set_active", bus_if.set_active, 1);
    step();
    bus_if.btn_level = 4'b0100;
    for (int t = 0; t < 31; t++) begin
      if (t == 21) bus_if.btn_level = 4'b1100;
      chk("t4_rpt_valid", bus_if.cmd_valid, (t == 10) || (t == 14) || (t == 18) || (t == 22));
      if ((t == 10) || (t == 14) || (t == 18) || (t == 22)) chk("t4_rpt_code", bus_if.cmd_code, 5);
      step();
    end
    chk("t4_mode_end", bus_if.mode, 1);
    bus_if.btn_level = 4'b0000;

    // Test 5a: idle timeout out of SET_MIN
    do_reset();
    bus_if.btn_pulse = 4'b0010;
    step();
    step();
    bus_if.btn_pulse = 4'b0000;
    chk("t5_mode_c2", bus_if.mode, 1);
    step();
    for (int t = 0; t < 67; t++) begin
      chk("t5a_mode", bus_if.mode, (t < 64) ? 2 : 0);
      chk("t5a_valid", bus_if.cmd_valid, (t == 0));
      step();
    end

    // Test 5b: an UP command at cycle 40 restarts the idle count
    do_reset();
    bus_if.btn_pulse = 4'b0010;
    step();
    step();
    bus_if.btn_pulse = 4'b0000;
    step();
    for (int t = 0; t < 109; t++) begin
      bus_if.btn_pulse = (t == 40) ? 4'b0100 : 4'b0000;
      chk("t5b_mode", bus_if.mode, (t < 106) ? 2 : 0);
      chk("t5b_valid", bus_if.cmd_valid, (t == 0) || (t == 42));
      if (t == 42) chk("t5b_code", bus_if.cmd_code, 3);
      step();
    end

    // Test 6: asynchronous reset during a stalled command with repeats pending
    do_reset();
    bus_if.cmd_ready = 1'b0;
    bus_if.btn_pulse = 4'b0010;
    step();
    bus_if.btn_pulse = 4'b0000;
    step();
    chk("t6_valid_pre", bus_if.cmd_valid, 1);
    bus_if.btn_level = 4'b0100;
    for (int k = 0; k < 15; k++) step();
    chk("t6_stall_valid", bus_if.cmd_valid, 1);
    chk("t6_stall_code", bus_if.cmd_code, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_valid", bus_if.cmd_valid, 0);
    chk("t6_async_code", bus_if.cmd_code, 0);
    chk("t6_async_mode", bus_if.mode, 0);
    chk("t6_async_overrun", bus_if.overrun, 0);
    chk("t6_async_set_active", bus_if.set_active, 0);
    bus_if.btn_level = 4'b0000;
    bus_if.cmd_ready = 1'b1;
    step();
    step();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t6_post_valid", bus_if.cmd_valid, 0);
      chk("t6_post_mode", bus_if.mode, 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_cmd_scheduler.md
Name: button_cmd_scheduler

Overview:
Sits between the four per-button debouncers and the clock/alarm/stopwatch datapaths. Queues the debounced one-cycle button pulses and arbitrates them into a single command stream with a valid/ready handshake. Generates auto-repeat commands for held UP/DOWN buttons and owns the display/edit mode FSM, including an inactivity timeout out of the edit modes.

Parameters:
HOLD_CYC, 50000000, cycles UP/DOWN must be held before the first repeat (0.5 s at 100 MHz)
REP_CYC, 10000000, cycles between subsequent repeats
TIMEOUT_CYC, 1000000000, idle cycles in an edit mode before the FSM forces TIME
CW, 32, width of all internal counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
btn_pulse  in  4  debounced one-cycle pulses; bit 0=MODE, 1=SEL, 2=UP, 3=DOWN
btn_level  in  4  synchronized raw button levels, same bit order
cmd_ready  in  1  consumer accepts cmd_code this cycle
cmd_valid  out  1  command available
cmd_code  out  3  1=MODE, 2=SEL, 3=UP, 4=DOWN, 5=UP_RPT, 6=DOWN_RPT
mode  out  3  0=TIME, 1=SET_HR, 2=SET_MIN, 3=ALM_HR, 4=ALM_MIN, 5=STOPWATCH
set_active  out  1  high when mode is 1 to 4
overrun  out  1  sticky; a pulse arrived while that button was already pending

Behaviour:
- Reset (reset=0, async): cmd_valid=0, cmd_code=0, mode=0, overrun=0. Clear pending[3:0], rpt_pending[1:0], the repeat FSM and all counters.
- Pending latch:
  - btn_pulse[i] sets pending[i] at the next edge.
  - A pulse arriving while pending[i]=1 and bit i is not being granted that edge leaves pending set and sets overrun.
  - If a pulse and a grant of the same bit occur on the same edge, the pulse wins and pending stays 1.
- Output slot:
  - The slot is free when cmd_valid=0, or when cmd_valid and cmd_ready are both high (acceptance).
  - On a free edge, grant the highest-priority request: MODE > SEL > UP > DOWN > UP_RPT > DOWN_RPT.
  - A grant loads cmd_code, sets cmd_valid and clears the granted bit.
  - With nothing pending on an accepting edge, cmd_valid drops to 0.
  - While cmd_valid=1 and cmd_ready=0, cmd_code is held stable.
  - Latency: a pulse in cycle N gives cmd_valid=1 in cycle N+2 if the slot is free. Throughput is one command per cycle.
- Mode FSM: updates on the grant edge, so mode is new in the same cycle cmd_valid rises.
  - MODE command: TIME goes to STOPWATCH; STOPWATCH goes to ALM_HR; any of SET_HR, SET_MIN, ALM_HR, ALM_MIN goes to TIME.
  - SEL command: TIME goes to SET_HR; SET_HR to SET_MIN; SET_MIN to TIME; ALM_HR to ALM_MIN; ALM_MIN to TIME. In STOPWATCH, SEL is passed through (start/stop) with no mode change.
  - UP/DOWN commands and repeat commands never change mode.
- Timeout:
  - The idle counter clears on any grant and on any mode change, and counts only while set_active=1.
  - When the count reaches TIMEOUT_CYC-1, mode becomes TIME on the next edge. No command is emitted.
  - Any pending MODE/SEL is then evaluated against TIME.
- Repeat FSM (states R_IDLE, R_HOLD, R_RPT), shared by UP and DOWN:
  - Active only while set_active=1. Otherwise it is forced to R_IDLE with the counter at 0.
  - R_IDLE to R_HOLD when exactly one of btn_level[2] or btn_level[3] is high. Latch which one; counter=0.
  - R_HOLD: count up. At HOLD_CYC-1, set the rpt_pending bit for the latched button, clear the counter and go to R_RPT.
  - R_RPT: at REP_CYC-1, set rpt_pending again and clear the counter.
  - In R_HOLD or R_RPT, if the latched level drops or both levels are high, go to R_IDLE.
  - A repeat that fires while its rpt_pending bit is already set is merged: not counted, no overrun.
- A mode change clears rpt_pending and returns the repeat FSM to R_IDLE.
- Counters saturate; they never wrap.

Test Plan:
Bench parameters: HOLD_CYC=8, REP_CYC=4, TIMEOUT_CYC=64.
1. Reset, then a single UP pulse at cycle 10 with cmd_ready=1 -> cmd_valid=1, cmd_code=3 only in cycle 12; mode=0, overrun=0.
2. MODE, UP and DOWN pulses in the same cycle, cmd_ready=1 -> codes 1, 3, 4 in three consecutive cycles; mode=5 from the first of them.
3. cmd_ready=0, SEL pulse, second SEL pulse 3 cycles later, third SEL pulse 2 cycles after that -> code 2 held stable, overrun=1 after the third pulse. Release ready -> exactly two SEL commands delivered (mode 0 to 1 to 2).
4. Enter SET_HR, hold btn_level[2] for 20 cycles, cmd_ready=1 -> UP_RPT (code 5) granted at hold+8, +12, +16, +20 (measured from the level edge plus 2). Then assert btn_level[3] as well -> no further repeats.
5. Enter SET_MIN, no input for 64 cycles -> mode=0 at cycle 64, cmd_valid stays 0. Repeat with an UP pulse at cycle 40 -> timeout at cycle 40+2+64.
6. Assert reset during a stalled command with repeats active -> all outputs at reset values immediately; no stale command after reset release.
